var_base: RTL and testbench
===========================

# var_base

Variable-side controller for a clause bin: the `base` end of the per-literal value bus that the literal cells consume. It holds the value, implied flag and decision level of `NUM_VARS` variables. It broadcasts them to the literal cells and runs the implication loop by collecting implications and conflicts back from those cells. It also executes decide and backtrack commands from the search controller.

## Interface
Parameters:
- `NUM_VARS`, 8, number of variables in the bin.
- `WIDTH_VAR_IDX`, 3, width of the variable index; `2**WIDTH_VAR_IDX >= NUM_VARS`.
- `WIDTH_LVL`, 8, width of the decision level.

Ports:
- `clk`  input  1  single clock; all state changes on its rising edge.
- `rst`  input  1  asynchronous, active-low reset.
- `decide_i`  input  1  one-cycle decide command; sampled only in IDLE.
- `decide_idx_i`  input  WIDTH_VAR_IDX  variable to assign.
- `decide_val_i`  input  1  value to assign: 1 = true, 0 = false.
- `decide_lvl_i`  input  WIDTH_LVL  new current decision level.
- `bkt_i`  input  1  one-cycle backtrack command; sampled only in IDLE.
- `bkt_lvl_i`  input  WIDTH_LVL  level to backtrack to.
- `var_value_tolit_o`  output  NUM_VARS*3  values to the literal cells; variable 0 occupies the MSB slice.
- `var_value_fromlit_i`  input  NUM_VARS*3  values/implications returned by the literal cells, same packing.
- `wr_o`  output  1  literal cells latch `var_value_tolit_o`.
- `imp_drv_o`  output  1  enables implication drive in the literal cells.
- `cclause_i`  input  1  OR of the cells' conflict-clause outputs.
- `busy_o`  output  1  high when the state is not IDLE.
- `done_o`  output  1  one-cycle completion pulse.
- `conflict_o`  output  1  result of the last operation; valid with `done_o` and held until the next `done_o`.
- `all_assigned_o`  output  1  high when no variable is free.

## Operation
**Slice encoding (3 bits):**
- [2] = implied flag.
- [1:0] = value: 00 free, 01 false, 10 true, 11 reserved.
- 11 is never driven and is treated as free on input.

**Per-variable state:** 2-bit value, implied bit, WIDTH_LVL level. Also a `cur_lvl` register.

**Registered FSM:** IDLE, WRITE, IMPLY, BKT_WR, DONE.
- **IDLE:**
  - If `bkt_i` is high (it wins over `decide_i`):
    - every variable with level > `bkt_lvl_i` becomes free, with implied = 0 and level = 0;
    - `cur_lvl` ← `bkt_lvl_i`;
    - next state BKT_WR.
  - Else if `decide_i` is high and the target variable is free:
    - value ← `decide_val_i` ? 10 : 01, implied = 0;
    - level and `cur_lvl` ← `decide_lvl_i`;
    - next state WRITE.
  - Else if `decide_i` is high and the target variable is assigned (or index ≥ NUM_VARS): no state change; next state DONE with `conflict_o` = 0.
- **WRITE:** `wr_o` = 1, `imp_drv_o` = 0 → IMPLY.
- **IMPLY:** `imp_drv_o` = 1. Sample `cclause_i` and `var_value_fromlit_i` in this cycle.
  - `cclause_i` = 1 → DONE, conflict = 1.
  - Else, for each slice with [2] = 1 and a valid value:
    - variable free → latch the value with implied = 1 and level = `cur_lvl`;
    - variable assigned to the opposite value → conflict.
  - If any conflict: DONE, conflict = 1. No latches are kept that cycle: all-or-nothing.
  - Else if at least one new variable was latched → WRITE.
  - Else → DONE, conflict = 0.
- **BKT_WR:** `wr_o` = 1 → DONE, conflict = 0.
- **DONE:** `done_o` = 1 → IDLE.

**Outputs:**
- `var_value_tolit_o` is driven directly from the state registers.
- `all_assigned_o` is combinational from the value registers.
- Termination is guaranteed: each WRITE/IMPLY round assigns ≥1 new variable, so there are at most NUM_VARS+1 IMPLY cycles per decide.

## Timing
**Reset:**
- All variables free, implied = 0, level = 0, `cur_lvl` = 0, state IDLE.
- `var_value_tolit_o` = 0, `wr_o` = `imp_drv_o` = `busy_o` = `done_o` = `conflict_o` = `all_assigned_o` = 0.
- Reset asserted mid-operation aborts immediately. No `done_o` is produced.

**Latencies:**
- Decide at edge t with no implications: `wr_o` high during t+1, `imp_drv_o` during t+2, `done_o` during t+3.
- Each implication round adds 2 cycles.
- Backtrack at t: `wr_o` during t+1, `done_o` during t+2.
- Rejected decide: `done_o` during t+1.

**Command sampling:**
- Commands that arrive while `busy_o` = 1 are ignored, not queued.
- `done_o` and `busy_o` are both high in the DONE cycle. The next command is accepted in the following IDLE cycle.

## Test plan
- **Reset then decide:** reset, then decide idx 2, val 1, lvl 1, with no lit implications → `var_value_tolit_o` slice 2 = 3'b010; `done_o` at t+3; `conflict_o` = 0.
- **Implication chain:** decide idx 0 = true at lvl 1; cells return implied var 3 = false on the first IMPLY, then nothing → slice 3 = 3'b101 with level 1; `wr_o` pulses twice; `done_o` at t+5.
- **Conflicts:**
  - `cclause_i` = 1 in IMPLY → `done_o` with `conflict_o` = 1, no new latches.
  - Implied true on a var already false → `conflict_o` = 1.
- **Backtrack:** vars at levels 1, 2, 3; backtrack to 1 → level-2/3 vars free; `cur_lvl` = 1; `done_o` at t+2; `all_assigned_o` = 0.
- **Rejected and busy commands:** decide on an assigned var → `done_o` at t+1, state unchanged. A decide pulsed while `busy_o` = 1 is ignored. `bkt_i` and `decide_i` together → backtrack only.
- **Async reset mid-IMPLY:** `rst` low → all outputs 0 immediately, no `done_o`.

Source files
------------

// File: rtl/var_base.sv
// Variable-side controller of a clause bin: holds per-variable value,
// implied flag and level, and runs decide / imply / backtrack rounds.
module var_base #(
  parameter int NUM_VARS      = 8,
  parameter int WIDTH_VAR_IDX = 3,
  parameter int WIDTH_LVL     = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     decide_i,
  input  logic [WIDTH_VAR_IDX-1:0] decide_idx_i,
  input  logic                     decide_val_i,
  input  logic [WIDTH_LVL-1:0]     decide_lvl_i,
  input  logic                     bkt_i,
  input  logic [WIDTH_LVL-1:0]     bkt_lvl_i,
  output logic [NUM_VARS*3-1:0]    var_value_tolit_o,
  input  logic [NUM_VARS*3-1:0]    var_value_fromlit_i,
  output logic                     wr_o,
  output logic                     imp_drv_o,
  input  logic                     cclause_i,
  output logic                     busy_o,
  output logic                     done_o,
  output logic                     conflict_o,
  output logic                     all_assigned_o
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_WRITE  = 3'd1;
  localparam logic [2:0] S_IMPLY  = 3'd2;
  localparam logic [2:0] S_BKT_WR = 3'd3;
  localparam logic [2:0] S_DONE   = 3'd4;

  logic [2:0]           state_q, state_d;
  logic [1:0]           val_q [NUM_VARS];
  logic [1:0]           val_d [NUM_VARS];
  logic                 imp_q [NUM_VARS];
  logic                 imp_d [NUM_VARS];
  logic [WIDTH_LVL-1:0] lvl_q [NUM_VARS];
  logic [WIDTH_LVL-1:0] lvl_d [NUM_VARS];
  logic [WIDTH_LVL-1:0] cur_lvl_q, cur_lvl_d;
  logic                 conflict_q, conflict_d;

  logic       tgt_free;
  logic       imp_conf;
  logic       imp_new;
  logic [2:0] lit;

  always_comb begin
    state_d    = state_q;
    val_d      = val_q;
    imp_d      = imp_q;
    lvl_d      = lvl_q;
    cur_lvl_d  = cur_lvl_q;
    conflict_d = conflict_q;
    tgt_free   = 1'b0;
    imp_conf   = 1'b0;
    imp_new    = 1'b0;
    lit        = '0;

    for (int i = 0; i < NUM_VARS; i++) begin
      if (decide_idx_i == WIDTH_VAR_IDX'(i) && val_q[i] == 2'b00)
        tgt_free = 1'b1;
    end

    case (state_q)
      S_IDLE: begin
        if (bkt_i) begin
          for (int i = 0; i < NUM_VARS; i++) begin
            if (lvl_q[i] > bkt_lvl_i) begin
              val_d[i] = 2'b00;
              imp_d[i] = 1'b0;
              lvl_d[i] = '0;
            end
          end
          cur_lvl_d = bkt_lvl_i;
          state_d   = S_BKT_WR;
        end else if (decide_i && tgt_free) begin
          for (int i = 0; i < NUM_VARS; i++) begin
            if (decide_idx_i == WIDTH_VAR_IDX'(i)) begin
              val_d[i] = decide_val_i ? 2'b10 : 2'b01;
              imp_d[i] = 1'b0;
              lvl_d[i] = decide_lvl_i;
            end
          end
          cur_lvl_d = decide_lvl_i;
          state_d   = S_WRITE;
        end else if (decide_i) begin
          conflict_d = 1'b0;
          state_d    = S_DONE;
        end
      end
      S_WRITE: state_d = S_IMPLY;
      S_IMPLY: begin
        for (int i = 0; i < NUM_VARS; i++) begin
          lit = var_value_fromlit_i[(NUM_VARS-1-i)*3 +: 3];
          if (lit[2] && (lit[1:0] == 2'b01 || lit[1:0] == 2'b10)) begin
            if (val_q[i] == 2'b00) begin
              val_d[i] = lit[1:0];
              imp_d[i] = 1'b1;
              lvl_d[i] = cur_lvl_q;
              imp_new  = 1'b1;
            end else if (val_q[i] != lit[1:0]) begin
              imp_conf = 1'b1;
            end
          end
        end
        // a conflicting round keeps none of its latches
        if (cclause_i || imp_conf) begin
          val_d      = val_q;
          imp_d      = imp_q;
          lvl_d      = lvl_q;
          conflict_d = 1'b1;
          state_d    = S_DONE;
        end else if (imp_new) begin
          state_d = S_WRITE;
        end else begin
          conflict_d = 1'b0;
          state_d    = S_DONE;
        end
      end
      S_BKT_WR: begin
        conflict_d = 1'b0;
        state_d    = S_DONE;
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= S_IDLE;
      cur_lvl_q  <= '0;
      conflict_q <= 1'b0;
      for (int i = 0; i < NUM_VARS; i++) begin
        val_q[i] <= 2'b00;
        imp_q[i] <= 1'b0;
        lvl_q[i] <= '0;
      end
    end else begin
      state_q    <= state_d;
      cur_lvl_q  <= cur_lvl_d;
      conflict_q <= conflict_d;
      val_q      <= val_d;
      imp_q      <= imp_d;
      lvl_q      <= lvl_d;
    end
  end

  always_comb begin
    var_value_tolit_o = '0;
    all_assigned_o    = 1'b1;
    for (int i = 0; i < NUM_VARS; i++) begin
      var_value_tolit_o[(NUM_VARS-1-i)*3 +: 3] = {imp_q[i], val_q[i]};
      if (val_q[i] == 2'b00)
        all_assigned_o = 1'b0;
    end
  end

  assign wr_o       = (state_q == S_WRITE) || (state_q == S_BKT_WR);
  assign imp_drv_o  = (state_q == S_IMPLY);
  assign busy_o     = (state_q != S_IDLE);
  assign done_o     = (state_q == S_DONE);
  assign conflict_o = conflict_q;

endmodule

// File: tb/tb_var_base.sv
// Directed bench for var_base: decide, implication rounds, conflicts,
// backtrack, rejected/ignored commands and asynchronous reset.
module tb_var_base;

  logic        clk;
  logic        rst;
  logic        decide_i;
  logic [2:0]  decide_idx_i;
  logic        decide_val_i;
  logic [7:0]  decide_lvl_i;
  logic        bkt_i;
  logic [7:0]  bkt_lvl_i;
  logic [23:0] tolit;
  logic [23:0] fromlit;
  logic        wr_o;
  logic        imp_drv_o;
  logic        cclause_i;
  logic        busy_o;
  logic        done_o;
  logic        conflict_o;
  logic        all_assigned_o;

  int pass_cnt = 0;
  int total    = 0;

  logic [2:0] es [8];

  var_base dut (
    .clk                 (clk),
    .rst                 (rst),
    .decide_i            (decide_i),
    .decide_idx_i        (decide_idx_i),
    .decide_val_i        (decide_val_i),
    .decide_lvl_i        (decide_lvl_i),
    .bkt_i               (bkt_i),
    .bkt_lvl_i           (bkt_lvl_i),
    .var_value_tolit_o   (tolit),
    .var_value_fromlit_i (fromlit),
    .wr_o                (wr_o),
    .imp_drv_o           (imp_drv_o),
    .cclause_i           (cclause_i),
    .busy_o              (busy_o),
    .done_o              (done_o),
    .conflict_o          (conflict_o),
    .all_assigned_o      (all_assigned_o)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [23:0] sl(input int i, input logic [2:0] v);
    logic [23:0] w;
    w = '0;
    w[(7-i)*3 +: 3] = v;
    return w;
  endfunction

  function automatic logic [23:0] pk();
    logic [23:0] w;
    w = '0;
    for (int i = 0; i < 8; i++) w[(7-i)*3 +: 3] = es[i];
    return w;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    total++;
    assert (obs === exp) pass_cnt++;
    else $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  // {wr, imp_drv, busy, done, conflict}
  task automatic chk_ctl(input string tag, input logic [4:0] exp);
    chk(tag, {59'd0, wr_o, imp_drv_o, busy_o, done_o, conflict_o},
        {59'd0, exp});
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic dec(input logic [2:0] idx, input logic v,
                     input logic [7:0] lvl);
    decide_i     = 1'b1;
    decide_idx_i = idx;
    decide_val_i = v;
    decide_lvl_i = lvl;
    step();
    decide_i = 1'b0;
  endtask

  initial begin
    rst = 1'b0;
    decide_i = 0; decide_idx_i = 0; decide_val_i = 0; decide_lvl_i = 0;
    bkt_i = 0; bkt_lvl_i = 0; fromlit = '0; cclause_i = 0;
    for (int i = 0; i < 8; i++) es[i] = 3'b000;

    #3;
    chk_ctl("reset_ctl", 5'b00000);
    chk("reset_tolit", tolit, 0);
    chk("reset_alla", all_assigned_o, 0);
    step();
    rst = 1'b1;
    step();

    // plain decide, no implications
    dec(3'd2, 1'b1, 8'd1);
    chk_ctl("d1_write", 5'b10100);
    step();
    chk_ctl("d1_imply", 5'b01100);
    es[2] = 3'b010;
    chk("d1_tolit", tolit, pk());
    step();
    chk_ctl("d1_done", 5'b00110);
    step();
    chk_ctl("d1_idle", 5'b00000);

    // one implication round
    dec(3'd0, 1'b1, 8'd1);
    chk_ctl("d2_write", 5'b10100);
    step();
    chk_ctl("d2_imply", 5'b01100);
    fromlit = sl(3, 3'b101);
    step();
    chk_ctl("d2_write2", 5'b10100);
    fromlit = '0;
    es[0] = 3'b010;
    es[3] = 3'b101;
    chk("d2_tolit", tolit, pk());
    step();
    chk_ctl("d2_imply2", 5'b01100);
    step();
    chk_ctl("d2_done", 5'b00110);
    step();

    // conflict clause in IMPLY, implied var must not latch
    dec(3'd1, 1'b0, 8'd2);
    step();
    cclause_i = 1'b1;
    fromlit = sl(4, 3'b110);
    step();
    chk_ctl("cc_done", 5'b00111);
    cclause_i = 1'b0;
    fromlit = '0;
    es[1] = 3'b001;
    chk("cc_tolit", tolit, pk());
    step();
    chk_ctl("cc_held", 5'b00001);

    // implied true on a var already false
    dec(3'd5, 1'b1, 8'd3);
    step();
    fromlit = sl(6, 3'b101) | sl(1, 3'b110);
    step();
    chk_ctl("ic_done", 5'b00111);
    fromlit = '0;
    es[5] = 3'b010;
    chk("ic_tolit", tolit, pk());
    step();

    // decide on an assigned var is rejected
    dec(3'd2, 1'b0, 8'd7);
    chk_ctl("rej_done", 5'b00110);
    chk("rej_tolit", tolit, pk());
    step();
    chk_ctl("rej_idle", 5'b00000);

    // decide while busy is ignored
    dec(3'd4, 1'b1, 8'd4);
    decide_i = 1'b1; decide_idx_i = 3'd6; decide_val_i = 1'b1;
    step();
    decide_i = 1'b0;
    step();
    chk_ctl("busy_done", 5'b00110);
    es[4] = 3'b010;
    chk("busy_tolit", tolit, pk());
    step();

    // backtrack wins over decide
    bkt_i = 1'b1; bkt_lvl_i = 8'd1;
    decide_i = 1'b1; decide_idx_i = 3'd6; decide_val_i = 1'b1;
    decide_lvl_i = 8'd5;
    step();
    bkt_i = 1'b0; decide_i = 1'b0;
    chk_ctl("bkt_wr", 5'b10100);
    step();
    chk_ctl("bkt_done", 5'b00110);
    es[1] = 3'b000; es[4] = 3'b000; es[5] = 3'b000;
    chk("bkt_tolit", tolit, pk());
    chk("bkt_alla", all_assigned_o, 0);
    chk("bkt_curlvl", dut.cur_lvl_q, 1);
    step();

    // fill every variable
    dec(3'd1, 1'b1, 8'd2);
    step();
    fromlit = sl(4, 3'b101) | sl(5, 3'b101) | sl(6, 3'b101) | sl(7, 3'b101);
    step();
    fromlit = '0;
    chk_ctl("fill_write2", 5'b10100);
    step();
    step();
    chk_ctl("fill_done", 5'b00110);
    es[1] = 3'b010;
    for (int i = 4; i < 8; i++) es[i] = 3'b101;
    chk("fill_tolit", tolit, pk());
    chk("fill_alla", all_assigned_o, 1);
    step();

    // backtrack to level 0 frees everything
    bkt_i = 1'b1; bkt_lvl_i = 8'd0;
    step();
    bkt_i = 1'b0;
    step();
    chk_ctl("bk0_done", 5'b00110);
    chk("bk0_tolit", tolit, 0);
    chk("bk0_alla", all_assigned_o, 0);
    step();

    // asynchronous reset mid-IMPLY
    dec(3'd0, 1'b1, 8'd1);
    step();
    chk_ctl("ar_imply", 5'b01100);
    #2;
    rst = 1'b0;
    #1;
    chk_ctl("ar_ctl", 5'b00000);
    chk("ar_tolit", tolit, 0);
    step();
    chk_ctl("ar_hold", 5'b00000);
    rst = 1'b1;
    step();
    chk_ctl("ar_after", 5'b00000);
    chk("ar_tolit2", tolit, 0);

    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end

endmodule
